data_mem_resp: RTL

//   Responder end of the CPU data-memory bus (mem_ren/mem_wen/mem_addr/mem_dout/mem_din).

---
 rtl/data_mem_resp.sv | 130 +++++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp: responder end of the CPU data-memory bus.
// It serves word loads and stores from an internal array after a programmable number of wait states.
// An ack/busy/err handshake lets multicycle CPUs stall until the access completes.
module data_mem_resp #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_din,
  output logic        mem_ack,
  output logic        mem_busy,
  output logic        mem_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  r_state, w_next;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_dout;
  logic [3:0]              r_be;
  logic                    r_wen;
  logic                    r_err;
  logic [31:0]             r_din;
  logic [31:0]             r_mem [DEPTH];

  logic                    w_req;
  logic                    w_err;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [ADDR_WIDTH-1:0]   w_ld_idx;
  logic                    w_ld_wen;
  logic                    w_ld_err;
  logic                    w_unused;

  // Word access only: the byte offset bits carry no information here.
  assign w_unused = &{1'b0, mem_addr[1:0]};

  assign w_req = mem_ren | mem_wen;
  assign w_idx = mem_addr[ADDR_WIDTH+1:2];
  // Conflicting ops, or any address bit above the array, reject the request.
  assign w_err = (mem_ren & mem_wen) | (|mem_addr[31:ADDR_WIDTH+2]);

  // With zero wait states the request goes straight from IDLE to RESP, before the latches are loaded.
  // So the read-data load takes the live request in IDLE and the latched request otherwise.
  assign w_ld_idx = (r_state == S_IDLE) ? w_idx   : r_idx;
  assign w_ld_wen = (r_state == S_IDLE) ? mem_wen : r_wen;
  assign w_ld_err = (r_state == S_IDLE) ? w_err   : r_err;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next   = r_state;
    mem_ack  = 1'b0;
    mem_busy = 1'b0;
    mem_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        mem_busy = 1'b1;
        if (r_cnt <= 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        mem_ack  = 1'b1;
        mem_busy = 1'b1;
        mem_err  = r_err;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_dout <= '0;
      r_be   <= '0;
      r_wen  <= 1'b0;
      r_err  <= 1'b0;
    end else if (r_state == S_IDLE && w_req) begin
      r_cnt  <= 4'(WAIT_STATES);
      r_idx  <= w_idx;
      r_dout <= mem_dout;
      r_be   <= mem_be;
      r_wen  <= mem_wen;
      r_err  <= w_err;
    end else if (r_state == S_WAIT) begin
      r_cnt  <= r_cnt - 4'd1;
    end
  end

  // Read data is loaded on entry to RESP, so it is valid together with the ack.
  // Writes leave it untouched, and errored requests clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_din <= '0;
    end else if (w_next == S_RESP) begin
      if (w_ld_err)      r_din <= '0;
      else if (!w_ld_wen) r_din <= r_mem[w_ld_idx];
    end
  end

  assign mem_din = r_din;

  // Byte-merged write commit at the RESP edge. The array is never cleared by reset.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_wen && !r_err) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_dout[8*b +: 8];
      end
    end
  end

endmodule
